// File: rtl/classifier_flow_etime_mgr.sv
// ----------------------------------------------------------------------------
// classifier_flow_etime_mgr
//
// Keeps a per-flow key table and a per-flow expiry-time (etime) table and runs
// a background ageing scanner over the etime table.
//
// Sources of etime writes, highest priority first:
//   * flow hits (touch_valid): stamp the flow with the upper ETIME_NBITS bits
//     of current_time.
//   * NUM_CH queued update channels, each behind a 2-entry FIFO, served
//     round-robin.
// After reset, an init sweep zeroes both tables one address per cycle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   current_time              free-running real time
//   touch_valid/touch_fid     flow-hit pulse and its flow id
//   upd_valid/fid/etime       per-channel expiry update (channel 0 in LSBs)
//   upd_ready                 per-channel FIFO can accept
//   key_wr/waddr/wdata        key table write
//   key_rd/raddr, key_ack/rdata        key table read, 1-cycle ack
//   etime_rd/raddr, etime_ack/rdata    etime table read, 1-cycle ack
//   scan_en                   enable the ageing scanner
//   aged_valid/aged_fid       expired-flow report pulse
//   init_done                 table clear sweep finished
//
// Handshake: an update on channel i is taken when upd_valid[i] and
// upd_ready[i] are both high in the same cycle. An update offered while
// upd_ready[i] is low is dropped. The read strobes have no backpressure: every
// read is acknowledged exactly one cycle later.
// ----------------------------------------------------------------------------
module classifier_flow_etime_mgr #(
    parameter int          NUM_CH      = 2,
    parameter int          DEPTH_NBITS = 12,
    parameter int          KEY_NBITS   = 104,
    parameter int          ETIME_NBITS = 16,
    parameter int          RTIME_NBITS = 32,
    parameter int unsigned AGE_LIMIT   = 32'h0000_0100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RTIME_NBITS-1:0]        current_time,
    input  logic                          touch_valid,
    input  logic [DEPTH_NBITS-1:0]        touch_fid,
    input  logic [NUM_CH-1:0]             upd_valid,
    input  logic [NUM_CH*DEPTH_NBITS-1:0] upd_fid,
    input  logic [NUM_CH*ETIME_NBITS-1:0] upd_etime,
    output logic [NUM_CH-1:0]             upd_ready,
    input  logic                          key_wr,
    input  logic [DEPTH_NBITS-1:0]        key_waddr,
    input  logic [KEY_NBITS-1:0]          key_wdata,
    input  logic                          key_rd,
    input  logic [DEPTH_NBITS-1:0]        key_raddr,
    output logic                          key_ack,
    output logic [KEY_NBITS-1:0]          key_rdata,
    input  logic                          etime_rd,
    input  logic [DEPTH_NBITS-1:0]        etime_raddr,
    output logic                          etime_ack,
    output logic [ETIME_NBITS-1:0]        etime_rdata,
    input  logic                          scan_en,
    output logic                          aged_valid,
    output logic [DEPTH_NBITS-1:0]        aged_fid,
    output logic                          init_done
);

    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ETIME_NBITS-1:0] AGE_LIM = ETIME_NBITS'(AGE_LIMIT);

    // Only the upper ETIME_NBITS of real time matter to this block.
    logic [ETIME_NBITS-1:0] now_etime;
    logic                   unused_time_lsbs;
    assign now_etime        = current_time[RTIME_NBITS-1 -: ETIME_NBITS];
    assign unused_time_lsbs = ^current_time[RTIME_NBITS-ETIME_NBITS-1:0];

    // ------------------------------------------------------------------
    // Init sweep FSM: INIT writes one address per cycle, LAST is the
    // cycle after the final write, RUN is normal operation.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {ST_INIT, ST_LAST, ST_RUN} init_state_e;

    init_state_e            init_state_q, init_state_d;
    logic [DEPTH_NBITS-1:0] init_ptr_q, init_ptr_d;
    logic                   init_we;
    logic                   run;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_state_q <= ST_INIT;
            init_ptr_q   <= '0;
        end else begin
            init_state_q <= init_state_d;
            init_ptr_q   <= init_ptr_d;
        end
    end

    always_comb begin
        init_state_d = init_state_q;
        init_ptr_d   = init_ptr_q;
        init_we      = 1'b0;
        case (init_state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) init_state_d = ST_LAST;
            end
            ST_LAST: init_state_d = ST_RUN;
            ST_RUN:  init_state_d = ST_RUN;
            default: init_state_d = ST_INIT;
        endcase
    end

    assign run       = (init_state_q == ST_RUN);
    assign init_done = run;

    // ------------------------------------------------------------------
    // Key table: writes are registered once, reads have 1-cycle latency.
    // ------------------------------------------------------------------
    logic [KEY_NBITS-1:0]   key_mem [DEPTH];
    logic                   key_wr_q;
    logic [DEPTH_NBITS-1:0] key_waddr_q;
    logic [KEY_NBITS-1:0]   key_wdata_q;
    logic                   key_ack_q;
    logic [KEY_NBITS-1:0]   key_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_wr_q  <= 1'b0;
            key_ack_q <= 1'b0;
        end else begin
            key_wr_q  <= key_wr & run;
            key_ack_q <= key_rd;
        end
    end

    always_ff @(posedge clk) begin
        key_waddr_q <= key_waddr;
        key_wdata_q <= key_wdata;
        if (init_we)       key_mem[init_ptr_q]  <= '0;
        else if (key_wr_q) key_mem[key_waddr_q] <= key_wdata_q;
        if (key_rd)        key_rdata_q <= key_mem[key_raddr];
    end

    assign key_ack   = key_ack_q;
    assign key_rdata = key_rdata_q;

    // ------------------------------------------------------------------
    // Touch capture stage
    // ------------------------------------------------------------------
    logic                   touch_v_q;
    logic [DEPTH_NBITS-1:0] touch_fid_q;
    logic [ETIME_NBITS-1:0] touch_et_q;

    always_ff @(posedge clk) begin
        if (rst) touch_v_q <= 1'b0;
        else     touch_v_q <= touch_valid & run;
    end

    always_ff @(posedge clk) begin
        touch_fid_q <= touch_fid;
        touch_et_q  <= now_etime;
    end

    // ------------------------------------------------------------------
    // Update channels: input register, then a 2-entry FIFO (entry 0 is
    // the head). upd_ready looks ahead at the in-flight push so the FIFO
    // can never be offered a third entry.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]                  pop;
    logic [NUM_CH-1:0][1:0]             cnt_vec;
    logic [NUM_CH-1:0][DEPTH_NBITS-1:0] head_fid_vec;
    logic [NUM_CH-1:0][ETIME_NBITS-1:0] head_et_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]             cnt_q;
        logic                   push_v_q;
        logic [DEPTH_NBITS-1:0] push_fid_q, fid0_q, fid1_q;
        logic [ETIME_NBITS-1:0] push_et_q, et0_q, et1_q;

        assign upd_ready[g] = run &&
                              ((cnt_q == 2'd0) || (cnt_q == 2'd1 && !push_v_q));

        always_ff @(posedge clk) begin
            push_fid_q <= upd_fid[g*DEPTH_NBITS +: DEPTH_NBITS];
            push_et_q  <= upd_etime[g*ETIME_NBITS +: ETIME_NBITS];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= 2'd0;
                push_v_q <= 1'b0;
            end else begin
                push_v_q <= upd_valid[g] & upd_ready[g];
                case ({push_v_q, pop[g]})
                    2'b10: begin
                        if (cnt_q == 2'd0) begin
                            fid0_q <= push_fid_q;
                            et0_q  <= push_et_q;
                        end else begin
                            fid1_q <= push_fid_q;
                            et1_q  <= push_et_q;
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b01: begin
                        fid0_q <= fid1_q;
                        et0_q  <= et1_q;
                        cnt_q  <= cnt_q - 2'd1;
                    end
                    2'b11: begin
                        // Pop and push together: occupancy unchanged.
                        if (cnt_q == 2'd1) begin
                            fid0_q <= push_fid_q;
                            et0_q  <= push_et_q;
                        end else begin
                            fid0_q <= fid1_q;
                            et0_q  <= et1_q;
                            fid1_q <= push_fid_q;
                            et1_q  <= push_et_q;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign cnt_vec[g]      = cnt_q;
        assign head_fid_vec[g] = fid0_q;
        assign head_et_vec[g]  = et0_q;
    end

    // ------------------------------------------------------------------
    // Etime write arbiter: a registered touch wins outright and stalls
    // every pop; otherwise the first non-empty FIFO at or after rr_ptr_q.
    // ------------------------------------------------------------------
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d, cand;
    logic                   found;
    logic                   wr_v_q, wr_v_d;
    logic [DEPTH_NBITS-1:0] wr_fid_q, wr_fid_d;
    logic [ETIME_NBITS-1:0] wr_et_q, wr_et_d;

    always_comb begin
        pop      = '0;
        cand     = '0;
        found    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        wr_v_d   = 1'b0;
        wr_fid_d = touch_fid_q;
        wr_et_d  = touch_et_q;
        if (touch_v_q) begin
            wr_v_d = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
                if (!found && cnt_vec[cand] != 2'd0) begin
                    found     = 1'b1;
                    pop[cand] = 1'b1;
                    wr_v_d    = 1'b1;
                    wr_fid_d  = head_fid_vec[cand];
                    wr_et_d   = head_et_vec[cand];
                    rr_ptr_d  = CH_W'((int'(cand) + 1) % NUM_CH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_v_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_v_q   <= wr_v_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_fid_q <= wr_fid_d;
        wr_et_q  <= wr_et_d;
    end

    // ------------------------------------------------------------------
    // Etime table: the single read port is shared; host reads win and the
    // scanner only issues in cycles without a host read.
    // ------------------------------------------------------------------
    logic [ETIME_NBITS-1:0] etime_mem [DEPTH];
    logic [ETIME_NBITS-1:0] etime_rdata_q;
    logic                   etime_ack_q;
    logic                   scan_issue;
    logic [DEPTH_NBITS-1:0] et_raddr;
    logic [DEPTH_NBITS-1:0] scan_ptr_q;

    assign scan_issue = scan_en & run & ~etime_rd;
    assign et_raddr   = etime_rd ? etime_raddr : scan_ptr_q;

    always_ff @(posedge clk) begin
        if (init_we)     etime_mem[init_ptr_q] <= '0;
        else if (wr_v_q) etime_mem[wr_fid_q]   <= wr_et_q;
        if (etime_rd | scan_issue) etime_rdata_q <= etime_mem[et_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) etime_ack_q <= 1'b0;
        else     etime_ack_q <= etime_rd;
    end

    assign etime_ack   = etime_ack_q;
    assign etime_rdata = etime_rdata_q;

    // ------------------------------------------------------------------
    // Ageing scanner. A write to the scanned address during the read or
    // response cycle makes the read data stale, so the report is dropped.
    // ------------------------------------------------------------------
    logic                   rsp_v_q, rsp_sup_q;
    logic [DEPTH_NBITS-1:0] rsp_fid_q;
    logic [ETIME_NBITS-1:0] age;
    logic                   hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr_q <= '0;
            rsp_v_q    <= 1'b0;
            rsp_sup_q  <= 1'b0;
            rsp_fid_q  <= '0;
        end else begin
            rsp_v_q <= scan_issue;
            if (scan_issue) begin
                scan_ptr_q <= scan_ptr_q + 1'b1;
                rsp_fid_q  <= scan_ptr_q;
                rsp_sup_q  <= wr_v_q && (wr_fid_q == scan_ptr_q);
            end
        end
    end

    assign age = now_etime - etime_rdata_q;
    assign hit = rsp_v_q && !rsp_sup_q &&
                 !(wr_v_q && (wr_fid_q == rsp_fid_q)) &&
                 (etime_rdata_q != '0) && (age >= AGE_LIM);

    assign aged_valid = hit;
    assign aged_fid   = hit ? rsp_fid_q : '0;

endmodule

// File: doc/classifier_flow_etime_mgr.md
CLASSIFIER_FLOW_ETIME_MGR -- requirements
Module: classifier_flow_etime_mgr

Interface
REQ-001 SHALL have parameters: NUM_CH, 2, number of queued expiry-update channels; DEPTH_NBITS, 12, flow-table address width; KEY_NBITS, 104, flow-key width; ETIME_NBITS, 16, expiry-time width; RTIME_NBITS, 32, real-time width; AGE_LIMIT, 16'h0100, ageing threshold in etime units.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- current_time  in  RTIME_NBITS  free-running real time.
- touch_valid  in  1  flow-hit pulse.
- touch_fid  in  DEPTH_NBITS  flow id of hit.
- upd_valid  in  NUM_CH  per-channel expiry update.
- upd_fid  in  NUM_CH*DEPTH_NBITS  packed fids, channel 0 in LSBs.
- upd_etime  in  NUM_CH*ETIME_NBITS  packed expiry times.
- upd_ready  out  NUM_CH  per-channel FIFO can accept.
- key_wr  in  1  key write strobe.
- key_waddr  in  DEPTH_NBITS  key write address.
- key_wdata  in  KEY_NBITS  key write data.
- key_rd  in  1  key read strobe.
- key_raddr  in  DEPTH_NBITS  key read address.
- key_ack  out  1  key read ack.
- key_rdata  out  KEY_NBITS  key read data.
- etime_rd  in  1  etime read strobe.
- etime_raddr  in  DEPTH_NBITS  etime read address.
- etime_ack  out  1  etime read ack.
- etime_rdata  out  ETIME_NBITS  etime read data.
- scan_en  in  1  enable ageing scanner.
- aged_valid  out  1  expired-flow report pulse.
- aged_fid  out  DEPTH_NBITS  expired flow id.
- init_done  out  1  RAM clear complete.

Function
REQ-003 SHALL hold one key RAM and one etime RAM, each 2^DEPTH_NBITS entries, 1 read + 1 write port, 1-cycle read latency.
REQ-004 SHALL, after reset, run init sweep writing 0 to addresses 0..2^DEPTH_NBITS-1 in both RAMs, one address per cycle; init_done SHALL rise the cycle after last address is written and stay high until reset.
REQ-005 SHALL, during init, force upd_ready=0 and ignore touch_valid, key_wr and scanner; host reads SHALL still be acked (data undefined).
REQ-006 key_wr SHALL be registered once; RAM write occurs cycle T+1 for strobe at T.
REQ-007 key_ack/etime_ack SHALL assert exactly one cycle after key_rd/etime_rd with RAM data for the address presented.
REQ-008 touch_valid at T SHALL capture touch_fid and current_time[RTIME_NBITS-1:RTIME_NBITS-ETIME_NBITS] at T; etime RAM write SHALL occur at T+2.
REQ-009 each update channel SHALL have a 2-entry FIFO; upd_valid with upd_ready=1 at T pushes at T+1; upd_valid with upd_ready=0 SHALL be dropped (no push, no state change).
REQ-010 upd_ready[i] SHALL deassert when FIFO i holds 2 entries or holds 1 entry with a push in flight.
REQ-011 etime write arbiter SHALL give registered touch absolute priority; otherwise SHALL pop one non-empty FIFO per cycle, round-robin starting after last-served channel (channel 0 first after reset); popped entry written 1 cycle after pop.
REQ-012 simultaneous touch and pending FIFOs SHALL stall all pops that cycle; no update SHALL be lost or duplicated.
REQ-013 scanner SHALL, when scan_en=1 and init_done=1, hold pointer starting at 0, issue an etime read only in cycles with etime_rd=0, advance pointer after each issued read, wrap 2^DEPTH_NBITS-1 -> 0.
REQ-014 scanner response (1 cycle after read) SHALL pulse aged_valid for one cycle with aged_fid=pointer read when etime!=0 and (now_etime - etime) mod 2^ETIME_NBITS >= AGE_LIMIT, now_etime = current_time upper ETIME_NBITS bits.
REQ-015 report SHALL be suppressed if an etime write to the same address occurs in the read or response cycle.
REQ-016 scan_en deassertion SHALL freeze pointer; outstanding response still reported.
REQ-017 all arithmetic SHALL be unsigned modulo its width.

Reset
REQ-018 rst SHALL clear: FIFOs empty, arbiter pointer to channel 0, scanner pointer 0, pipeline valids 0; outputs key_ack=0, etime_ack=0, aged_valid=0, aged_fid=0, init_done=0, upd_ready=0.
REQ-019 rst mid-operation SHALL discard queued updates and restart init sweep from address 0.

Verification
REQ-020 reset, DEPTH_NBITS=4 -> init_done rises cycle 17; reads of all addresses return 0.
REQ-021 touch fid=5, current_time=0x12340000 at T -> etime read at T+3 returns 0x1234.
REQ-022 upd_valid on ch0 and ch1 (fids 1,2, etimes 0xA,0xB) same cycle, plus touch fid 3 the following cycle -> writes order fid3, fid1, fid2; no loss.
REQ-023 three back-to-back upd_valid on ch0 with no drain (touch held every cycle) -> third sees upd_ready=0 and is dropped; two entries later written.
REQ-024 fid 7 etime=0x0010, now=0x0200, AGE_LIMIT=0x100, scan_en=1 -> one aged_valid with aged_fid=7 per sweep; fid with etime 0 never reported.
REQ-025 etime wrap: etime=0xFFF0, now=0x00F0 -> difference 0x100 reported; host etime_rd held high -> scanner issues no reads.
